serial_adder_ctrl: RTL
======================

// Module: serial_adder_ctrl
// PURPOSE
//  Sequencer that performs a WIDTH-bit addition on one single-bit FA_design cell.
//  It loads operands through a valid/ready handshake, then processes one bit per clock, LSB first.
//  The carry is held in a flop between bits. The result is returned through a valid/ready handshake.
//  It is the area-minimal alternative to the parallel carry-select datapath.
// PARAMETERS
//  WIDTH   8   operand/result width in bits; legal range >= 2
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      operands A, B, Cin valid
//  in_ready   out  1      block can accept operands
//  A          in   WIDTH  operand A
//  B          in   WIDTH  operand B
//  Cin        in   1      carry-in
//  out_valid  out  1      Sum/Cout valid
//  out_ready  in   1      consumer accepts result
//  Sum        out  WIDTH  result, registered
//  Cout       out  1      carry-out, registered
//  busy       out  1      high while in RUN or DONE
// BEHAVIOUR
//  Clock/reset: one clock (clk). rst is asynchronous, active-high.
//    While rst=1: state=IDLE; shift regs, carry flop, counter, Sum and Cout = 0; out_valid=0; busy=0.
//  Internal state: a_sr and b_sr (WIDTH each); sum_sr (WIDTH); carry flop; cnt ($clog2(WIDTH) bits).
//    One FA_design instance is wired A=a_sr[0], B=b_sr[0], C=carry.
//  FSM IDLE:
//    in_ready=1 (combinational: state==IDLE).
//    On in_valid: load a_sr=A, b_sr=B, carry=Cin; clear cnt; go to RUN.
//  FSM RUN, every cycle:
//    sum_sr <= {fa_sum, sum_sr[WIDTH-1:1]}.
//    a_sr and b_sr shift right 1 (zero-filled).
//    carry <= fa_carry; cnt++.
//    When cnt==WIDTH-1, go to DONE. RUN therefore lasts exactly WIDTH cycles.
//  FSM DONE:
//    out_valid=1; Sum=sum_sr; Cout=carry.
//    Sum and Cout are held stable until out_ready=1. Then go to IDLE on that edge.
//  Latency: operand accepted on edge t; out_valid rises after edge t+WIDTH.
//  Throughput: WIDTH+2 cycles per operation. This assumes out_ready=1 and in_valid is held.
//    DONE->IDLE consumes one edge; the next accept happens at the following edge.
//  Handshake rules:
//    in_valid is ignored outside IDLE. Operand ports are sampled only on the accept edge.
//    Changes to A, B or Cin during RUN have no effect.
//    out_valid never drops without out_ready. A/B/Cin need not be held after accept.
//  Sum/Cout outside DONE: they show sum_sr and carry. They are meaningful only when out_valid=1.
//  Width rule: Sum is (A+B+Cin) mod 2^WIDTH. Cout is bit WIDTH of that sum.
//  Reset mid-operation (RUN or DONE): the operation is discarded with no output.
//    Outputs return to reset values immediately (asynchronous).
//    in_ready=1 in the first cycle after rst falls.
//  Simultaneous in_valid and out_ready in DONE: no accept in that cycle. Accept follows in IDLE.
// TESTING
//  1. WIDTH=8, A=0x5A, B=0x3C, Cin=0 -> Sum=0x96, Cout=0.
//     out_valid rises exactly 8 edges after accept.
//  2. A=0xFF, B=0x01, Cin=0 -> Sum=0x00, Cout=1 (full carry ripple through all bits).
//  3. A=0xFF, B=0xFF, Cin=1 -> Sum=0xFF, Cout=1.
//     Also A=0x00, B=0x00, Cin=0 -> Sum=0x00, Cout=0.
//  4. Backpressure: hold out_ready=0 for 5 cycles in DONE.
//     Sum, Cout and out_valid stay stable; in_ready=0.
//     A new in_valid with A=0x11 is ignored; the result is still the original.
//  5. Reset in RUN: assert rst on cycle 3 of RUN.
//     All outputs read 0 and out_valid=0 at once; in_ready=1 after release.
//     The next op, 0x10+0x20, gives 0x30.
//  6. Back-to-back: in_valid held high and out_ready=1, 4 operations.
//     Each result is correct; successive accepts are spaced 10 cycles apart (WIDTH+2).

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: operands are accepted on a valid/ready handshake,
// summed LSB first through one full-adder cell, and returned on a valid/ready handshake.

module FA_design (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);
    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (c & (a ^ b));
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             busy
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           next_state_s;
    logic [WIDTH-1:0] a_sr_r;
    logic [WIDTH-1:0] b_sr_r;
    logic [WIDTH-1:0] sum_sr_r;
    logic             carry_r;
    logic [CW-1:0]    cnt_r;
    logic             fa_sum_s;
    logic             fa_carry_s;

    FA_design u_fa (
        .a     (a_sr_r[0]),
        .b     (b_sr_r[0]),
        .c     (carry_r),
        .sum   (fa_sum_s),
        .carry (fa_carry_s)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; RUN spans exactly WIDTH edges
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    next_state_s = RUN;
                end else begin
                    next_state_s = IDLE;
                end
            end
            RUN: begin
                if (cnt_r == CNT_LAST) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = DONE;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Handshake and status outputs decoded from the state flop
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_r)
            IDLE:    in_ready = 1'b1;
            RUN:     busy = 1'b1;
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: in_ready = 1'b0;
        endcase
    end

    // Operand shift registers, carry flop, result shift register and bit counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr_r   <= '0;
            b_sr_r   <= '0;
            sum_sr_r <= '0;
            carry_r  <= 1'b0;
            cnt_r    <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        a_sr_r  <= A;
                        b_sr_r  <= B;
                        carry_r <= Cin;
                        cnt_r   <= '0;
                    end
                end
                RUN: begin
                    sum_sr_r <= {fa_sum_s, sum_sr_r[WIDTH-1:1]};
                    a_sr_r   <= {1'b0, a_sr_r[WIDTH-1:1]};
                    b_sr_r   <= {1'b0, b_sr_r[WIDTH-1:1]};
                    carry_r  <= fa_carry_s;
                    cnt_r    <= cnt_r + CNT_ONE;
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    // Result ports come straight from flops, so they are stable throughout DONE
    assign Sum  = sum_sr_r;
    assign Cout = carry_r;

endmodule
